alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares a single `alu` instance between two requesters, e.g. the execute stage and a multi-cycle helper unit such as a multiplier or debug port. Each request is a valid/ready transaction carrying operands and an `alu_control_t` opcode. The block grants one request at a time in round-robin order, registers the operands, captures the ALU outputs, and returns a registered response on a valid/ready channel to the requester that was granted. It sits between the requesters and the ALU; nothing else drives the ALU inputs.

---
 rtl/alu_arbiter_pkg.sv | 33 +++
 rtl/alu.sv | 49 ++++
 rtl/alu_arbiter_rr.sv | 15 +
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU types: opcode encoding, arbiter FSM states and an opcode legality check.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0001,
        ALU_OR  = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0101,
        ALU_SLT = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_ADD = 4'b1000,
        ALU_SUB = 4'b1100,
        ALU_SRL = 4'b1101,
        ALU_SRA = 4'b1111
    } alu_control_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic is_legal_alu_op(alu_control_t op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
            ALU_SLL, ALU_ADD, ALU_SUB, ALU_SRL, ALU_SRA: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; undefined opcodes produce a zero result and no overflow.
module alu
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_control_t op_i,
    output logic [N-1:0] result_o,
    output logic         overflow_o,
    output logic         zero_o,
    output logic         equal_o
);

    logic [N-1:0] sum;
    logic [N-1:0] diff;
    logic         slt;

    always_comb begin
        sum        = a_i + b_i;
        diff       = a_i - b_i;
        slt        = $signed(a_i) < $signed(b_i);
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = {{(N-1){1'b0}}, slt};
            ALU_SLL: result_o = a_i << b_i[4:0];
            ALU_SRL: result_o = a_i >> b_i[4:0];
            ALU_SRA: result_o = $signed(a_i) >>> b_i[4:0];
            ALU_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            ALU_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
            end
            default: result_o = '0;
        endcase
        zero_o  = (result_o == '0);
        equal_o = (a_i == b_i);
    end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Two-requester round-robin arbiter; the port that was not granted last wins a tie.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any
);

    always_comb begin
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
        any      = |req;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; IDLE -> EXEC -> RESP per operation.
module alu_arbiter
    import alu_types::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][N-1:0]     req_a,
    input  logic [1:0][N-1:0]     req_b,
    input  alu_control_t [1:0]    req_op,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [N-1:0]          rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_zero,
    output logic                  rsp_equal,
    output logic                  rsp_illegal,
    output logic                  busy,
    output logic [1:0][CNT_W-1:0] op_count
);

    arb_state_t            state_q;
    logic                  owner_q;
    logic                  last_q;
    logic [N-1:0]          a_q;
    logic [N-1:0]          b_q;
    alu_control_t          op_q;
    logic [1:0]            rsp_valid_q;
    logic [N-1:0]          result_q;
    logic                  overflow_q;
    logic                  zero_q;
    logic                  equal_q;
    logic                  illegal_q;
    logic [1:0][CNT_W-1:0] op_count_q;

    logic [1:0]   grant;
    logic         any;
    logic         win;
    logic [N-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_equal;

    rr_arbiter2 u_rr (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant),
        .any   (any)
    );

    // ALU sees only the operand registers, so its inputs move once per operation.
    alu #(.N(N)) u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .op_i       (op_q),
        .result_o   (alu_result),
        .overflow_o (alu_overflow),
        .zero_o     (alu_zero),
        .equal_o    (alu_equal)
    );

    always_comb begin
        win       = grant[1];
        req_ready = (rst && state_q == IDLE) ? grant : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= alu_control_t'('0);
            rsp_valid_q <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            equal_q     <= 1'b0;
            illegal_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any) begin
                        a_q     <= req_a[win];
                        b_q     <= req_b[win];
                        op_q    <= req_op[win];
                        owner_q <= win;
                        last_q  <= win;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result;
                    overflow_q  <= alu_overflow;
                    zero_q      <= alu_zero;
                    equal_q     <= alu_equal;
                    illegal_q   <= ~is_legal_alu_op(op_q);
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        if (op_count_q[owner_q] != '1)
                            op_count_q[owner_q] <= op_count_q[owner_q] + CNT_W'(1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid    = rsp_valid_q;
        rsp_result   = result_q;
        rsp_overflow = overflow_q;
        rsp_zero     = zero_q;
        rsp_equal    = equal_q;
        rsp_illegal  = illegal_q;
        busy         = (state_q != IDLE);
        op_count     = op_count_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_alu_arbiter;
    import alu_types::*;

    localparam int N     = 32;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][N-1:0]     req_a;
    logic [1:0][N-1:0]     req_b;
    alu_control_t [1:0]    req_op;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [N-1:0]          rsp_result;
    logic                  rsp_overflow;
    logic                  rsp_zero;
    logic                  rsp_equal;
    logic                  rsp_illegal;
    logic                  busy;
    logic [1:0][CNT_W-1:0] op_count;

    alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_equal    (rsp_equal),
        .rsp_illegal  (rsp_illegal),
        .busy         (busy),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    typedef struct packed {
        logic [31:0] r;
        logic        ovf;
        logic        zero;
        logic        eq;
        logic        ill;
    } rsp_t;

    function automatic rsp_t ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        rsp_t   o;
        longint sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        o  = '0;
        case (op)
            4'b1000: begin s = sa + sb; o.r = s[31:0]; o.ovf = (s > 64'sd2147483647) || (s < -(64'sd2147483648)); end
            4'b1100: begin s = sa - sb; o.r = s[31:0]; o.ovf = (s > 64'sd2147483647) || (s < -(64'sd2147483648)); end
            4'b0001: o.r = a & b;
            4'b0010: o.r = a | b;
            4'b0011: o.r = a ^ b;
            4'b0101: o.r = ~(a | b);
            4'b0110: o.r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0111: o.r = a << b[4:0];
            4'b1101: o.r = a >> b[4:0];
            4'b1111: begin s = sa >>> b[4:0]; o.r = s[31:0]; end
            default: o.ill = 1'b1;
        endcase
        o.zero = (o.r == 32'd0);
        o.eq   = (a == b);
        return o;
    endfunction

    function automatic int pick(logic [1:0] v, int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return v[0] ? 0 : 1;
    endfunction

    // Transaction model: one accepted op is pending until its response handshake.
    bit   m_pend;
    int   m_age;
    int   m_owner;
    int   m_last;
    int   m_cnt [2];
    rsp_t m_rsp;
    rsp_t m_next;

    always @(posedge clk) begin : model
        int w;
        if (!rst) begin
            m_pend  <= 0;
            m_age   <= 0;
            m_owner <= 0;
            m_last  <= 1;
            m_cnt   <= '{0, 0};
            m_rsp   <= '0;
        end else if (!m_pend) begin
            if (req_valid != 2'b00) begin
                w = pick(req_valid, m_last);
                m_owner <= w;
                m_last  <= w;
                m_next  <= ref_alu(req_a[w], req_b[w], req_op[w]);
                m_pend  <= 1;
                m_age   <= 0;
            end
        end else if (m_age == 0) begin
            m_age <= 1;
            m_rsp <= m_next;
        end else if (rsp_ready[m_owner]) begin
            if (m_cnt[m_owner] < CMAX) m_cnt[m_owner] <= m_cnt[m_owner] + 1;
            m_pend <= 0;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] er;
        logic [1:0] ev;
        if (chk_en) begin
            er = (rst && !m_pend && req_valid != 2'b00) ? (2'b01 << pick(req_valid, m_last)) : 2'b00;
            ev = (m_pend && m_age == 1) ? (2'b01 << m_owner) : 2'b00;
            chk("m_req_ready", req_ready, er);
            chk("m_busy", busy, m_pend);
            chk("m_rsp_valid", rsp_valid, ev);
            chk("m_result", rsp_result, m_rsp.r);
            chk("m_overflow", rsp_overflow, m_rsp.ovf);
            chk("m_zero", rsp_zero, m_rsp.zero);
            chk("m_equal", rsp_equal, m_rsp.eq);
            chk("m_illegal", rsp_illegal, m_rsp.ill);
            chk("m_count0", op_count[0], m_cnt[0]);
            chk("m_count1", op_count[1], m_cnt[1]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 2'b01;
        req_a[0]  = 32'h7FFF_FFFF; req_b[0] = 32'd1; req_op[0] = ALU_ADD;
        req_a[1]  = '0;            req_b[1] = '0;    req_op[1] = ALU_AND;
        rsp_ready = 2'b01;

        // reset held two cycles with port 0 requesting
        step(1); chk_en = 1;
        step(1); #1;
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", op_count, '0);

        // single add with overflow
        rst = 1'b1; #1;
        chk("add_req_ready", req_ready, 2'b01);
        step(1); req_valid = 2'b00; #1;
        chk("add_exec_busy", busy, 1'b1);
        chk("add_exec_novalid", rsp_valid, 2'b00);
        step(1); #1;
        chk("add_rsp_valid", rsp_valid, 2'b01);
        chk("add_result", rsp_result, 32'h8000_0000);
        chk("add_overflow", rsp_overflow, 1'b1);
        chk("add_zero", rsp_zero, 1'b0);
        step(1); #1;
        chk("add_count0", op_count[0], 1);
        chk("add_idle", busy, 1'b0);

        // simultaneous requests straight after reset
        rst = 1'b0; step(1);
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_a[0] = 32'd5;      req_b[0] = 32'd5;      req_op[0] = ALU_SUB;
        req_a[1] = 32'hF0F0;   req_b[1] = 32'h0FF0;   req_op[1] = ALU_AND;
        #1 chk("sim_first_p0", req_ready, 2'b01);
        step(1); req_valid = 2'b10;
        step(1); #1;
        chk("sim_p0_valid", rsp_valid, 2'b01);
        chk("sim_p0_result", rsp_result, 32'd0);
        chk("sim_p0_zero", rsp_zero, 1'b1);
        chk("sim_p0_equal", rsp_equal, 1'b1);
        step(1); #1;
        chk("sim_p1_ready", req_ready, 2'b10);
        step(1); req_valid = 2'b00;
        step(1); #1;
        chk("sim_p1_valid", rsp_valid, 2'b10);
        chk("sim_p1_result", rsp_result, 32'h0000_00F0);
        step(1);
        req_valid = 2'b11;
        req_a[0] = 32'd1;      req_b[0] = 32'd2;      req_op[0] = ALU_OR;
        req_a[1] = 32'd7;      req_b[1] = 32'd9;      req_op[1] = ALU_XOR;
        #1 chk("sim_rr_back_p0", req_ready, 2'b01);
        step(1); req_valid = 2'b00;
        step(3);

        // back-pressure on port 0 while port 1 waits
        req_valid = 2'b01; rsp_ready = 2'b10;
        req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd2; req_op[0] = ALU_SLT;
        step(1);
        req_valid = 2'b10;
        req_a[1] = 32'h1234; req_b[1] = 32'h00FF; req_op[1] = ALU_XOR;
        #1 chk("bp_exec_ready", req_ready, 2'b00);
        step(1); #1;
        chk("bp_valid", rsp_valid, 2'b01);
        chk("bp_result", rsp_result, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1); #1;
            chk("bp_hold_valid", rsp_valid, 2'b01);
            chk("bp_hold_ready", req_ready, 2'b00);
            chk("bp_hold_result", rsp_result, 32'd1);
        end
        rsp_ready = 2'b01;
        step(1); #1;
        chk("bp_release_idle", busy, 1'b0);
        chk("bp_p1_ready", req_ready, 2'b10);
        step(1); req_valid = 2'b00; rsp_ready = 2'b10;
        step(1); #1;
        chk("bp_p1_valid", rsp_valid, 2'b10);
        chk("bp_p1_result", rsp_result, 32'h0000_12CB);
        step(1);

        // illegal opcode on port 1
        req_valid = 2'b10;
        req_a[1] = 32'd3; req_b[1] = 32'd4; req_op[1] = alu_control_t'(4'b1001);
        step(1); req_valid = 2'b00;
        step(1); #1;
        chk("ill_flag", rsp_illegal, 1'b1);
        chk("ill_result", rsp_result, 32'd0);
        step(1); #1;
        chk("ill_count1", op_count[1], 3);

        // counter saturation on port 0 (count 3 plus six more ops)
        req_valid = 2'b01; rsp_ready = 2'b01;
        req_a[0] = 32'h0000_0010; req_b[0] = 32'd3; req_op[0] = ALU_SRA;
        step(18); req_valid = 2'b00;
        step(2); #1;
        chk("sat_count0", op_count[0], CMAX);

        // reset while a response is pending
        req_valid = 2'b01; rsp_ready = 2'b00;
        req_a[0] = 32'd10; req_b[0] = 32'd20; req_op[0] = ALU_ADD;
        step(1); req_valid = 2'b00;
        step(1); #1;
        chk("mid_pending", rsp_valid, 2'b01);
        rst = 1'b0;
        step(1); #1;
        chk("mid_rsp_valid", rsp_valid, 2'b00);
        chk("mid_busy", busy, 1'b0);
        chk("mid_count", op_count, '0);
        rst = 1'b1; rsp_ready = 2'b11;
        step(4); #1;
        chk("mid_no_stale", rsp_valid, 2'b00);
        chk("mid_result_cleared", rsp_result, 32'd0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
